// File: rtl/mem_access_stage_if.sv
// Bundle of the EX-side offer, data-memory bus and write-back signals of the memory access stage.
// The master modport is the stage's view; the slave modport is the surrounding pipeline/memory.
interface mem_access_stage_if;
  logic        in_mem_valid;
  logic        out_mem_ready;
  logic [5:0]  in_mem_op;
  logic [31:0] in_mem_addr;
  logic [63:0] in_mem_wdata;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  logic        out_wb_valid;
  logic [63:0] out_wb_data;
  logic        out_wb_is64;
  logic        out_mem_err;

  modport master (
    input  in_mem_valid, in_mem_op, in_mem_addr, in_mem_wdata,
    output out_mem_ready,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata,
    output out_wb_valid, out_wb_data, out_wb_is64, out_mem_err
  );

  modport slave (
    output in_mem_valid, in_mem_op, in_mem_addr, in_mem_wdata,
    input  out_mem_ready,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata,
    input  out_wb_valid, out_wb_data, out_wb_is64, out_mem_err
  );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: turns one EX result into zero, one or two 32-bit bus beats with an
// ACK timeout, then presents a single-cycle write-back result.
module mem_access_stage #(
  parameter int ACK_TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_stage_if.master bus
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  localparam logic [5:0] OP_LBU  = 6'h22;
  localparam logic [5:0] OP_LW   = 6'h12;
  localparam logic [5:0] OP_SB   = 6'h28;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_LWC1 = 6'h31;
  localparam logic [5:0] OP_LDC1 = 6'h35;
  localparam logic [5:0] OP_SWC1 = 6'h39;
  localparam logic [5:0] OP_SDC1 = 6'h3d;

  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  function automatic logic is_mem_op(input logic [5:0] op);
    case (op)
      OP_LBU, OP_LW, OP_SB, OP_SW, OP_LWC1, OP_LDC1, OP_SWC1, OP_SDC1: is_mem_op = 1'b1;
      default: is_mem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_store_op(input logic [5:0] op);
    case (op)
      OP_SB, OP_SW, OP_SWC1, OP_SDC1: is_store_op = 1'b1;
      default: is_store_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_byte_op(input logic [5:0] op);
    is_byte_op = (op == OP_LBU) || (op == OP_SB);
  endfunction

  function automatic logic is_dbl_op(input logic [5:0] op);
    is_dbl_op = (op == OP_LDC1) || (op == OP_SDC1);
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [2:0] low);
    case (op)
      OP_LW, OP_SW, OP_LWC1, OP_SWC1: is_misaligned = (low[1:0] != 2'b00);
      OP_LDC1, OP_SDC1:               is_misaligned = (low != 3'b000);
      default:                        is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] lane);
    case (lane)
      2'd0:    pick_byte = w[7:0];
      2'd1:    pick_byte = w[15:8];
      2'd2:    pick_byte = w[23:16];
      default: pick_byte = w[31:24];
    endcase
  endfunction

  state_t        state;
  logic [5:0]    op_q;
  logic [31:0]   addr_q;
  logic [63:0]   wdata_q;
  logic [31:0]   rdata_lo;
  logic [CW-1:0] beat_cnt;
  logic [63:0]   load_result;

  assign bus.out_mem_ready = (state == IDLE);

  // Write-back value for a beat that completes now; stores always write back zero.
  always_comb begin
    load_result = 64'b0;
    if (!is_store_op(op_q)) begin
      if (is_byte_op(op_q)) begin
        load_result = {56'b0, pick_byte(bus.dmem_rdata, addr_q[1:0])};
      end else if (is_dbl_op(op_q)) begin
        load_result = {bus.dmem_rdata, rdata_lo};
      end else begin
        load_result = {32'b0, bus.dmem_rdata};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      op_q             <= 6'b0;
      addr_q           <= 32'b0;
      wdata_q          <= 64'b0;
      rdata_lo         <= 32'b0;
      beat_cnt         <= '0;
      bus.dmem_req     <= 1'b0;
      bus.dmem_we      <= 1'b0;
      bus.dmem_addr    <= 32'b0;
      bus.dmem_wdata   <= 32'b0;
      bus.dmem_be      <= 4'b0;
      bus.out_wb_valid <= 1'b0;
      bus.out_wb_data  <= 64'b0;
      bus.out_wb_is64  <= 1'b0;
      bus.out_mem_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_mem_valid) begin
            op_q    <= bus.in_mem_op;
            addr_q  <= bus.in_mem_addr;
            wdata_q <= bus.in_mem_wdata;
            if (is_misaligned(bus.in_mem_op, bus.in_mem_addr[2:0])) begin
              state            <= RESP;
              bus.out_wb_valid <= 1'b1;
              bus.out_wb_data  <= 64'b0;
              bus.out_wb_is64  <= is_dbl_op(bus.in_mem_op);
              bus.out_mem_err  <= 1'b1;
            end else if (!is_mem_op(bus.in_mem_op)) begin
              state            <= RESP;
              bus.out_wb_valid <= 1'b1;
              bus.out_wb_data  <= {32'b0, bus.in_mem_addr};
              bus.out_wb_is64  <= 1'b0;
              bus.out_mem_err  <= 1'b0;
            end else begin
              state         <= BEAT0;
              beat_cnt      <= '0;
              bus.dmem_req  <= 1'b1;
              bus.dmem_we   <= is_store_op(bus.in_mem_op);
              bus.dmem_addr <= {bus.in_mem_addr[31:2], 2'b00};
              bus.dmem_be   <= is_byte_op(bus.in_mem_op) ?
                               (4'b0001 << bus.in_mem_addr[1:0]) : 4'b1111;
              if (!is_store_op(bus.in_mem_op)) begin
                bus.dmem_wdata <= 32'b0;
              end else if (is_byte_op(bus.in_mem_op)) begin
                bus.dmem_wdata <= {4{bus.in_mem_wdata[7:0]}};
              end else begin
                bus.dmem_wdata <= bus.in_mem_wdata[31:0];
              end
            end
          end
        end

        // Both beats share the ACK/timeout handling; only a double op's first beat chains on.
        BEAT0, BEAT1: begin
          if (bus.dmem_ack) begin
            beat_cnt <= '0;
            if (state == BEAT0 && is_dbl_op(op_q)) begin
              state          <= BEAT1;
              rdata_lo       <= bus.dmem_rdata;
              bus.dmem_addr  <= bus.dmem_addr + 32'd4;
              bus.dmem_wdata <= bus.dmem_we ? wdata_q[63:32] : 32'b0;
            end else begin
              state            <= RESP;
              bus.dmem_req     <= 1'b0;
              bus.dmem_we      <= 1'b0;
              bus.dmem_addr    <= 32'b0;
              bus.dmem_wdata   <= 32'b0;
              bus.dmem_be      <= 4'b0;
              bus.out_wb_valid <= 1'b1;
              bus.out_wb_data  <= load_result;
              bus.out_wb_is64  <= is_dbl_op(op_q);
              bus.out_mem_err  <= 1'b0;
            end
          end else if (beat_cnt == CNT_LAST) begin
            state            <= RESP;
            beat_cnt         <= '0;
            bus.dmem_req     <= 1'b0;
            bus.dmem_we      <= 1'b0;
            bus.dmem_addr    <= 32'b0;
            bus.dmem_wdata   <= 32'b0;
            bus.dmem_be      <= 4'b0;
            bus.out_wb_valid <= 1'b1;
            bus.out_wb_data  <= 64'b0;
            bus.out_wb_is64  <= is_dbl_op(op_q);
            bus.out_mem_err  <= 1'b1;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end

        RESP: begin
          state            <= IDLE;
          bus.out_wb_valid <= 1'b0;
          bus.out_wb_data  <= 64'b0;
          bus.out_wb_is64  <= 1'b0;
          bus.out_mem_err  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255, SHALL be the number of consecutive cycles a bus beat may wait for DMEM_ACK before it is aborted.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 RST_N  in  1  asynchronous active-low reset.
REQ-005 IN_MEM_VALID  in  1  an EX-stage result is offered.
REQ-006 OUT_MEM_READY  out  1  the stage can accept an offer.
REQ-007 IN_MEM_OP  in  6  opcode: 0x22 LBU, 0x12 LW, 0x28 SB, 0x2b SW, 0x31 LWC1, 0x35 LDC1, 0x39 SWC1, 0x3d SDC1; any other value is a non-memory op.
REQ-008 IN_MEM_ADDR  in  32  ALU 32-bit result; this is the effective address for memory ops.
REQ-009 IN_MEM_WDATA  in  64  store data; bits [31:0] are used for single-word and byte stores.
REQ-010 DMEM_REQ / DMEM_WE  out  1 / 1  bus request and write enable.
REQ-011 DMEM_ADDR / DMEM_WDATA / DMEM_BE  out  32 / 32 / 4  word address, write data and byte enables.
REQ-012 DMEM_ACK / DMEM_RDATA  in  1 / 32  beat completion and read data.
REQ-013 OUT_WB_VALID / OUT_WB_DATA / OUT_WB_IS64 / OUT_MEM_ERR  out  1 / 64 / 1 / 1  write-back result signals.

Function
REQ-014 The FSM SHALL have the states IDLE, BEAT0, BEAT1 and RESP; OUT_MEM_READY SHALL equal (state==IDLE).
REQ-015 On a rising edge with IN_MEM_VALID and OUT_MEM_READY both high, the stage SHALL latch op, address and wdata, then take the first matching transition:
- misaligned -> RESP;
- non-memory op -> RESP;
- otherwise -> BEAT0.
REQ-016 Misaligned SHALL mean:
- LW/SW/LWC1/SWC1 with addr[1:0] != 0;
- LDC1/SDC1 with addr[2:0] != 0.
A misaligned access SHALL cause no bus activity, OUT_MEM_ERR=1 and OUT_WB_DATA=0.
REQ-017 For a non-memory op, OUT_WB_DATA SHALL be {32'b0, latched addr}, with OUT_MEM_ERR=0.
REQ-018 In BEAT0 and BEAT1, DMEM_REQ SHALL be high, with DMEM_ADDR/WE/WDATA/BE held stable until DMEM_ACK is sampled high.
REQ-019 DMEM_ACK SHALL be ignored while DMEM_REQ is low.
REQ-020 Bus address and byte enables:
- DMEM_ADDR = {addr[31:2], 2'b00};
- DMEM_BE = 4'b1111 for word accesses;
- DMEM_BE = one-hot (1 << addr[1:0]) for LBU/SB.
REQ-021 SB SHALL drive the wdata[7:0] byte replicated on all four lanes.
REQ-022 LBU SHALL return the addressed byte lane of DMEM_RDATA, zero-extended to 64 bits.
REQ-023 LDC1/SDC1 SHALL use two beats:
- BEAT0 at addr, BEAT1 at addr+4 (32-bit wrap-around allowed);
- SDC1 writes wdata[31:0] in BEAT0 and wdata[63:32] in BEAT1;
- LDC1 result = {BEAT1 rdata, BEAT0 rdata};
- DMEM_REQ stays high between the beats, and the address advances in the cycle after the BEAT0 ACK.
REQ-024 LW/LWC1 SHALL return {32'b0, rdata}; all stores SHALL return OUT_WB_DATA=0.
REQ-025 OUT_WB_IS64 SHALL be 1 only for LDC1/SDC1.
REQ-026 A per-beat counter SHALL reset at each beat start; if it reaches ACK_TIMEOUT with no ACK, the stage SHALL:
- drop DMEM_REQ in the next cycle;
- go to RESP with OUT_MEM_ERR=1 and OUT_WB_DATA=0;
- not issue BEAT1.
REQ-027 An ACK sampled in the same cycle the counter reaches ACK_TIMEOUT SHALL count as success.
REQ-028 In RESP, OUT_WB_VALID SHALL be high for exactly one cycle, with WB_DATA/IS64/ERR valid in that cycle; the next state SHALL be IDLE, with no write-back backpressure.
REQ-029 Latency, with accept at edge 0:
- non-memory or misaligned: OUT_WB_VALID in cycle 1, READY in cycle 2;
- memory with ACK at the first opportunity: REQ in cycle 1, WB_VALID in cycle 2 (single beat) or cycle 3 (double).
REQ-030 Outside RESP, OUT_WB_DATA/IS64/ERR SHALL hold 0.

Reset
REQ-031 While RST_N is low, regardless of clock:
- state = IDLE;
- DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_BE = 0;
- OUT_WB_VALID, OUT_WB_DATA, OUT_WB_IS64, OUT_MEM_ERR = 0;
- OUT_MEM_READY = 1;
- timeout counter = 0.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no OUT_WB_VALID pulse for it; the first accept SHALL be possible on the first rising edge after RST_N rises.

Verification
REQ-033 LW, addr 0x100, ACK in the first REQ cycle, RDATA 0xDEADBEEF -> DMEM_BE 0xF; WB_VALID one cycle in cycle 2; WB_DATA 0x00000000DEADBEEF, ERR 0.
REQ-034 SB, addr 0x203, wdata[7:0] 0x5A -> DMEM_ADDR 0x200, BE 0x8, WDATA 0x5A5A5A5A, WE 1; then LBU, addr 0x201, RDATA 0x11223344 -> WB_DATA 0x33.
REQ-035 SDC1, addr 0x3F8, wdata 0xAAAAAAAA_55555555, ACK delayed 3 cycles per beat -> beat 0x3F8/0x55555555, then 0x3FC/0xAAAAAAAA; REQ stable while waiting; WB_IS64 1.
REQ-036 LW, addr 0x102 -> no DMEM_REQ; WB_VALID in cycle 1 with ERR 1, DATA 0; non-memory op 0x00, addr 0x1234 -> WB_DATA 0x1234, ERR 0.
REQ-037 LDC1 with ACK_TIMEOUT=4 and no ACK -> REQ drops after 4 cycles, ERR 1, no BEAT1 issued; RST_N pulsed low during BEAT0 of a new LW -> REQ 0 at once, no WB_VALID, READY 1.
